// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and encodings for the multi-cycle MIPS controller
// Purpose: state enumeration, opcode/func constants, ALU and mux encodings,
//          and the per-state control word decode used by multicycle_control_fsm.
// Ports:   none (package).
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_ADDIEX,
    S_ADDIWB,
    S_BRANCH,
    S_JUMP,
    S_TRAP
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type func codes (IR[5:0])
  localparam logic [5:0] FN_NOP = 6'b000000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALUCntrl codes
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // pcSrc encodings
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Registered part of the control word; mem_ready-qualified strobes are
  // added outside this struct.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_cntrl;
    logic       instr_done;
  } ctrl_t;

  // Control word asserted while sitting in state s. exec_alu is only
  // consulted for S_EXEC.
  function automatic ctrl_t ctrl_decode(input state_t s, input logic [3:0] exec_alu);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
      end
      S_DECODE: c.alu_src_b = SRCB_IMM_SH;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_cntrl = exec_alu;
      end
      S_ALUWB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 1'b1;
        c.instr_done = 1'b1;
      end
      S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_cntrl     = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_src        = PC_ALUOUT;
        c.instr_done    = 1'b1;
      end
      S_JUMP: begin
        c.pc_write   = 1'b1;
        c.pc_src     = PC_JUMP;
        c.instr_done = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_func_decode.sv
// rtl/alu_func_decode.sv - R-type func field to ALUCntrl mapping with legality flag
// Purpose: combinational func -> ALUCntrl map; legal=0 for unsupported funcs.
// Ports:   func (in, 6)  IR[5:0]
//          alu_cntrl (out, 4) ALU operation code, ADD when not legal
//          legal (out, 1) func is one of ADD/SUB/AND/OR/SLT
module alu_func_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] func,
  output logic [3:0] alu_cntrl,
  output logic       legal
);

  always_comb begin
    alu_cntrl = ALU_ADD;
    legal     = 1'b1;
    case (func)
      FN_ADD:  alu_cntrl = ALU_ADD;
      FN_SUB:  alu_cntrl = ALU_SUB;
      FN_AND:  alu_cntrl = ALU_AND;
      FN_OR:   alu_cntrl = ALU_OR;
      FN_SLT:  alu_cntrl = ALU_SLT;
      default: legal     = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle MIPS subset controller with memory wait/timeout
// Purpose: sequences shared ALU, unified memory and register file for
//          ADD/SUB/AND/OR/SLT/LW/SW/ADDI/BEQ/J (+NOP); traps illegal
//          encodings and memory timeouts.
// Ports:   clk, rst_n (async active-low); op_in/func_in from IR;
//          zero_in (unused, datapath gates it); mem_ready handshake;
//          datapath strobes/mux selects; instr_done pulse;
//          illegal_op / mem_timeout sticky trap flags.
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter  int WAIT_LIMIT = 255,
  localparam int WCNT_W     = $clog2(WAIT_LIMIT + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op_in,
  input  logic [5:0] func_in,
  input  logic       zero_in,
  input  logic       mem_ready,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic [1:0] pcSrc,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       memToReg,
  output logic       regWrite,
  output logic       regDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUCntrl,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout
);

  state_t              state;
  state_t              nxt_state;
  logic [WCNT_W-1:0]   wcnt;
  logic [WCNT_W-1:0]   wcnt_nxt;
  ctrl_t               ctrl_q;
  logic                illegal_q;
  logic                timeout_q;
  logic                in_wait;
  logic                timeout_hit;
  logic                illegal_hit;
  logic                is_nop;
  logic [3:0]          func_alu;
  logic                func_legal;

  // zero_in is ANDed with pcWriteCond in the datapath, not here.
  logic unused_zero;
  assign unused_zero = zero_in;

  alu_func_decode u_func_dec (
    .func      (func_in),
    .alu_cntrl (func_alu),
    .legal     (func_legal)
  );

  assign is_nop  = (op_in == OP_RTYPE) && (func_in == FN_NOP);
  assign in_wait = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);

  always_comb begin
    nxt_state   = state;
    illegal_hit = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_RESET:  nxt_state = S_FETCH;
      S_FETCH:  if (mem_ready) nxt_state = S_DECODE;
      S_DECODE: begin
        case (op_in)
          OP_LW, OP_SW: nxt_state = S_MEMADR;
          OP_RTYPE: begin
            if (is_nop) begin
              nxt_state = S_FETCH;
            end else if (func_legal) begin
              nxt_state = S_EXEC;
            end else begin
              nxt_state   = S_TRAP;
              illegal_hit = 1'b1;
            end
          end
          OP_ADDI:  nxt_state = S_ADDIEX;
          OP_BEQ:   nxt_state = S_BRANCH;
          OP_J:     nxt_state = S_JUMP;
          default: begin
            nxt_state   = S_TRAP;
            illegal_hit = 1'b1;
          end
        endcase
      end
      S_MEMADR: nxt_state = (op_in == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) nxt_state = S_MEMWB;
      S_MEMWB:  nxt_state = S_FETCH;
      S_MEMWR:  if (mem_ready) nxt_state = S_FETCH;
      S_EXEC:   nxt_state = S_ALUWB;
      S_ALUWB:  nxt_state = S_FETCH;
      S_ADDIEX: nxt_state = S_ADDIWB;
      S_ADDIWB: nxt_state = S_FETCH;
      S_BRANCH: nxt_state = S_FETCH;
      S_JUMP:   nxt_state = S_FETCH;
      S_TRAP:   nxt_state = S_TRAP;
      default:  nxt_state = S_RESET;
    endcase

    // The cycle that would bring the count to WAIT_LIMIT traps, unless
    // mem_ready arrives in that same cycle.
    if (in_wait && !mem_ready && (wcnt == WCNT_W'(WAIT_LIMIT - 1))) begin
      timeout_hit = 1'b1;
      nxt_state   = S_TRAP;
    end

    // Only a stalled wait state counts; every other path (ready, leaving,
    // entering a new wait state) starts from zero.
    wcnt_nxt = (in_wait && !mem_ready) ? wcnt + WCNT_W'(1) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RESET;
      wcnt      <= '0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state  <= nxt_state;
      wcnt   <= wcnt_nxt;
      // Outputs are registered as the decode of the state being entered,
      // so they always equal the decode of the current state.
      ctrl_q <= ctrl_decode(nxt_state, func_alu);
      if (illegal_hit) illegal_q <= 1'b1;
      if (timeout_hit) timeout_q <= 1'b1;
    end
  end

  // Strobes that depend on the handshake or on IR contents in the current state.
  assign pcWrite     = ctrl_q.pc_write | ((state == S_FETCH) & mem_ready);
  assign irWrite     = (state == S_FETCH) & mem_ready;
  assign instr_done  = ctrl_q.instr_done
                     | ((state == S_MEMWR) & mem_ready)
                     | ((state == S_DECODE) & is_nop);

  assign pcWriteCond = ctrl_q.pc_write_cond;
  assign pcSrc       = ctrl_q.pc_src;
  assign iorD        = ctrl_q.iord;
  assign memRead     = ctrl_q.mem_read;
  assign memWrite    = ctrl_q.mem_write;
  assign memToReg    = ctrl_q.mem_to_reg;
  assign regWrite    = ctrl_q.reg_write;
  assign regDst      = ctrl_q.reg_dst;
  assign ALUSrcA     = ctrl_q.alu_src_a;
  assign ALUSrcB     = ctrl_q.alu_src_b;
  assign ALUCntrl    = ctrl_q.alu_cntrl;
  assign illegal_op  = illegal_q;
  assign mem_timeout = timeout_q;

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multi-cycle controller for the MIPS subset ADD, SUB, AND, OR, SLT, LW, SW, ADDI, BEQ and J. It sequences one shared ALU, one unified instruction/data memory and the register file over 3–5 states per instruction. It sits between the instruction register (op/func fields) and the datapath muxes and strobes. It stalls on a memory ready handshake and traps illegal encodings and memory timeouts.

Parameters:
- WAIT_LIMIT, 255: maximum number of consecutive cycles spent waiting for mem_ready in any memory state before a timeout trap.
- WCNT_W, $clog2(WAIT_LIMIT+1): width of the wait counter (derived; not overridden).

Ports:
- clk, in, 1: rising-edge clock.
- rst_n, in, 1: asynchronous active-low reset.
- op_in, in, 6: IR[31:26]; stable outside FETCH.
- func_in, in, 6: IR[5:0].
- zero_in, in, 1: ALU zero flag; the datapath gates it, shown for completeness.
- mem_ready, in, 1: memory completes the access this cycle.
- pcWrite, out, 1: unconditional PC load.
- pcWriteCond, out, 1: PC load if zero_in (datapath ANDs).
- pcSrc, out, 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- iorD, out, 1: 0 = PC address, 1 = ALUOut address.
- memRead, out, 1: memory read request.
- memWrite, out, 1: memory write request.
- irWrite, out, 1: IR load.
- memToReg, out, 1: 1 = MDR, 0 = ALUOut to register file.
- regWrite, out, 1: register file write.
- regDst, out, 1: 0 = rt, 1 = rd.
- ALUSrcA, out, 1: 0 = PC, 1 = register A.
- ALUSrcB, out, 2: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- ALUCntrl, out, 4: 0000 ADD, 0001 SUB, 0010 AND, 0100 SLT, 0101 OR.
- instr_done, out, 1: one-cycle pulse marking instruction retirement.
- illegal_op, out, 1: sticky trap flag for an illegal encoding.
- mem_timeout, out, 1: sticky trap flag for a memory timeout.

Behaviour:
- Moore machine: all outputs decode from the state register only. Exception: in wait states, pcWrite and irWrite are additionally qualified by mem_ready.
- Every output not listed for a state is 0. ALUCntrl defaults to 0000, ALUSrcB and pcSrc default to 00. No X values are ever driven.
- Reset (asynchronous, rst_n=0): state enters RESET, all outputs 0, wait counter 0. Asserting reset mid-instruction aborts it with no further strobes.
- RESET: all outputs 0; next state FETCH.
- FETCH: memRead=1, iorD=0, ALUSrcA=0, ALUSrcB=01, ALU=ADD, pcSrc=00. irWrite and pcWrite equal mem_ready. Stay in FETCH while !mem_ready; go to DECODE on mem_ready.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALU=ADD (precomputes the branch target). Next state:
  - op 100011 or 101011 → MEMADR.
  - op 000000 with func 100000, 100010, 100100, 100101 or 101010 → EXEC.
  - op 000000 with func 000000 (NOP) → FETCH, instr_done=1.
  - op 001000 → ADDIEX.
  - op 000100 → BRANCH.
  - op 000010 → JUMP.
  - Anything else → TRAP with illegal_op set.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALU=ADD. Next state MEMRD for LW, MEMWR for SW.
- MEMRD: memRead=1, iorD=1. Wait for mem_ready, then MEMWB.
- MEMWB: regWrite=1, regDst=0, memToReg=1, instr_done=1; next state FETCH.
- MEMWR: memWrite=1, iorD=1. Wait for mem_ready; on the ready cycle instr_done=1 and next state FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUCntrl decoded from func_in; next state ALUWB.
- ALUWB: regWrite=1, regDst=1, memToReg=0, instr_done=1; next state FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALU=ADD; next state ADDIWB.
- ADDIWB: regWrite=1, regDst=0, memToReg=0, instr_done=1; next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALU=SUB, pcWriteCond=1, pcSrc=01, instr_done=1; next state FETCH.
- JUMP: pcWrite=1, pcSrc=10, instr_done=1; next state FETCH.
- Wait counter (FETCH, MEMRD, MEMWR):
  - Clears on entering any wait state and on mem_ready.
  - Increments each cycle the machine is in a wait state with !mem_ready.
  - When it reaches WAIT_LIMIT with !mem_ready still low: mem_timeout=1 and next state TRAP.
  - mem_ready on that same cycle wins and completes the access normally.
- TRAP: all strobes 0; illegal_op/mem_timeout hold their values; only reset exits.
- Latency in cycles, assuming zero-wait memory (mem_ready=1 on the first cycle):
  - LW: 5.
  - SW, R-type, ADDI: 4.
  - BEQ, J: 3.
  - NOP: 2.
  - Each cycle mem_ready is low adds 1.

Decomposition:
- ctrl_pkg:
  - State enumeration (RESET, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, TRAP).
  - Opcode and func constants.
  - ALUCntrl codes.
  - ALUSrcB and pcSrc encodings.
- Sub-module: alu_func_decode, a combinational func → ALUCntrl mapping with a legal flag. It is used in DECODE for legality and in EXEC for the code.

Test Plan:
- rst_n low mid-MEMRD, op=100011 → all outputs 0 immediately; after release, RESET then FETCH with memRead=1, iorD=0.
- ADD (op 000000, func 100000), mem_ready always 1 → states FETCH, DECODE, EXEC (ALUCntrl=0000, ALUSrcA=1, ALUSrcB=00), ALUWB (regWrite=1, regDst=1); instr_done on cycle 4.
- LW with mem_ready low for 3 cycles in MEMRD → memRead/iorD held for 4 cycles; MEMWB asserts regWrite=1, memToReg=1, regDst=0; total 8 cycles.
- BEQ then J → BRANCH asserts ALUCntrl=0001, pcWriteCond=1, pcSrc=01; JUMP asserts pcWrite=1, pcSrc=10; 3 cycles each.
- op=111111 → DECODE, then TRAP with illegal_op=1 held for 20 cycles; no memRead or regWrite.
- WAIT_LIMIT=4, mem_ready stuck low in FETCH → mem_timeout=1 and TRAP after 4 wait cycles; second run with mem_ready rising on cycle 4 → normal DECODE, no timeout.
